muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit
//    Iterative multiply/divide unit for the EX stage. Owns the HI/LO
//    registers, runs one radix-2 iteration per cycle for WIDTH cycles,
//    applies sign correction in a single FIX cycle and stalls the pipeline
//    while an operation is in flight.
//
// Ports
//    clk    : clock, all state changes on the rising edge
//    reset  : synchronous active-high reset
//    start  : request an operation (accepted only in IDLE, not in the done cycle)
//    op     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//    a, b   : multiplicand/dividend, multiplier/divisor
//    flush  : abort the operation in progress, blocks a new start
//    hi_we  : MTHI write enable (IDLE only)
//    lo_we  : MTLO write enable (IDLE only)
//    wdata  : MTHI/MTLO data
//    busy   : operation in progress (CALC or FIX)
//    stall  : pipeline stall request, busy | (start & ~done)
//    done   : one-cycle pulse, new HI/LO visible in the same cycle
//    hi, lo : HI/LO registers
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [CW-1:0]      count_r;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   mag_b_r;
   logic               a_neg_r;
   logic               b_neg_r;
   logic [WIDTH-1:0]   acc_r;      // product high half / partial remainder
   logic [WIDTH-1:0]   q_r;        // multiplier shifting out / quotient shifting in
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               done_r;

   logic               accept_s;
   logic               load_s;
   logic               last_s;
   logic               signed_op_s;
   logic               a_neg_s;
   logic               b_neg_s;
   logic [WIDTH-1:0]   mag_a_s;
   logic [WIDTH-1:0]   mag_b_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     div_shift_s;
   logic [WIDTH:0]     div_trial_s;
   logic [WIDTH-1:0]   acc_nxt_s;
   logic [WIDTH-1:0]   q_nxt_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_fix_s;
   logic [WIDTH-1:0]   fix_hi_s;
   logic [WIDTH-1:0]   fix_lo_s;

   assign last_s = (count_r == CW'(WIDTH - 1));
   assign busy   = (state_r != IDLE);
   assign stall  = busy | (start & ~done_r);
   assign done   = done_r;
   assign hi     = hi_r;
   assign lo     = lo_r;

   // Next-state decode plus accept/load strobes.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      load_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (start && !done_r && !flush) begin
               state_nxt_s = CALC;
               accept_s    = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CALC: begin
            if (flush) begin
               state_nxt_s = IDLE;
            end else if (last_s) begin
               state_nxt_s = FIX;
            end else begin
               state_nxt_s = CALC;
            end
         end
         FIX: begin
            state_nxt_s = IDLE;
            if (flush) begin
               load_s = 1'b0;
            end else begin
               load_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Operand magnitudes; only the signed ops (op[0]=0) can be negative.
   always_comb begin
      signed_op_s = ~op[0];
      a_neg_s     = signed_op_s & a[WIDTH-1];
      b_neg_s     = signed_op_s & b[WIDTH-1];
      if (a_neg_s) begin
         mag_a_s = {WIDTH{1'b0}} - a;
      end else begin
         mag_a_s = a;
      end
      if (b_neg_s) begin
         mag_b_s = {WIDTH{1'b0}} - b;
      end else begin
         mag_b_s = b;
      end
   end

   // One shift-add (multiply) or restoring-subtract (divide) iteration.
   always_comb begin
      if (q_r[0]) begin
         mul_sum_s = {1'b0, acc_r} + {1'b0, mag_b_r};
      end else begin
         mul_sum_s = {1'b0, acc_r};
      end
      div_shift_s = {acc_r, q_r[WIDTH-1]};
      div_trial_s = div_shift_s - {1'b0, mag_b_r};
      if (op_r[1]) begin
         // A borrow out of the trial subtraction means the divisor did not fit.
         if (div_trial_s[WIDTH]) begin
            acc_nxt_s = div_shift_s[WIDTH-1:0];
            q_nxt_s   = {q_r[WIDTH-2:0], 1'b0};
         end else begin
            acc_nxt_s = div_trial_s[WIDTH-1:0];
            q_nxt_s   = {q_r[WIDTH-2:0], 1'b1};
         end
      end else begin
         acc_nxt_s = mul_sum_s[WIDTH:1];
         q_nxt_s   = {mul_sum_s[0], q_r[WIDTH-1:1]};
      end
   end

   // Sign correction and special cases applied in FIX.
   always_comb begin
      prod_s     = {acc_r, q_r};
      prod_fix_s = prod_s;
      fix_hi_s   = hi_r;
      fix_lo_s   = lo_r;
      if (!op_r[1]) begin
         if (a_neg_r ^ b_neg_r) begin
            prod_fix_s = {(2*WIDTH){1'b0}} - prod_s;
         end else begin
            prod_fix_s = prod_s;
         end
         fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
         fix_lo_s = prod_fix_s[WIDTH-1:0];
      end else if (mag_b_r == {WIDTH{1'b0}}) begin
         fix_hi_s = a_r;
         fix_lo_s = {WIDTH{1'b1}};
      end else begin
         // Most-negative / -1 falls out naturally: negating 2^(WIDTH-1) wraps to itself.
         if (a_neg_r ^ b_neg_r) begin
            fix_lo_s = {WIDTH{1'b0}} - q_r;
         end else begin
            fix_lo_s = q_r;
         end
         if (a_neg_r) begin
            fix_hi_s = {WIDTH{1'b0}} - acc_r;
         end else begin
            fix_hi_s = acc_r;
         end
      end
   end

   // FSM state, iteration counter, latched operands and working registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         count_r <= {CW{1'b0}};
         op_r    <= 2'b00;
         a_r     <= {WIDTH{1'b0}};
         mag_b_r <= {WIDTH{1'b0}};
         a_neg_r <= 1'b0;
         b_neg_r <= 1'b0;
         acc_r   <= {WIDTH{1'b0}};
         q_r     <= {WIDTH{1'b0}};
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         done_r  <= load_s;
         if (accept_s) begin
            op_r    <= op;
            a_r     <= a;
            mag_b_r <= mag_b_s;
            a_neg_r <= a_neg_s;
            b_neg_r <= b_neg_s;
            acc_r   <= {WIDTH{1'b0}};
            q_r     <= mag_a_s;
            count_r <= {CW{1'b0}};
         end else if (state_r == CALC) begin
            acc_r   <= acc_nxt_s;
            q_r     <= q_nxt_s;
            count_r <= count_r + CW'(1);
         end
      end
   end

   // HI/LO: result load on FIX->IDLE, MTHI/MTLO only while IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_r <= {WIDTH{1'b0}};
         lo_r <= {WIDTH{1'b0}};
      end else if (load_s) begin
         hi_r <= fix_hi_s;
         lo_r <= fix_lo_s;
      end else if (state_r == IDLE) begin
         if (hi_we) begin
            hi_r <= wdata;
         end
         if (lo_we) begin
            lo_r <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   localparam int WIDTH = 32;

   logic              clk;
   logic              reset;
   logic              start;
   logic [1:0]        op;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              flush;
   logic              hi_we;
   logic              lo_we;
   logic [WIDTH-1:0]  wdata;
   logic              busy;
   logic              stall;
   logic              done;
   logic [WIDTH-1:0]  hi;
   logic [WIDTH-1:0]  lo;

   int                n_checks;
   int                n_pass;
   logic [WIDTH-1:0]  m_hi;
   logic [WIDTH-1:0]  m_lo;
   int                seen;
   logic [1:0]        r_op;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   int                sel;

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .stall (stall),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic, returns {hi, lo}.
   function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
      longint     sx;
      longint     sy;
      longint     sq;
      longint     sr;
      logic [63:0] res;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'b00: res = sx * sy;
         2'b01: res = {32'h0, x} * {32'h0, y};
         2'b10: begin
            if (y == 32'h0) begin
               res = {x, 32'hFFFFFFFF};
            end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
               res = {32'h0, 32'h80000000};
            end else begin
               sq  = sx / sy;
               sr  = sx % sy;
               res = {sr[31:0], sq[31:0]};
            end
         end
         default: begin
            if (y == 32'h0) begin
               res = {x, 32'hFFFFFFFF};
            end else begin
               res = {x % y, x / y};
            end
         end
      endcase
      return res;
   endfunction

   // Full operation: start in cycle 0, busy 1..WIDTH+1, done at WIDTH+2.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit keep_start);
      logic [63:0] r;
      r     = ref_model(o, x, y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      #1;
      check("stall_c0", stall, 1'b1);
      check("busy_c0", busy, 1'b0);
      tick();
      // Operand changes and extra starts after acceptance must not matter.
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom);
      if (!keep_start) start = 1'b0;
      for (int c = 1; c <= WIDTH + 1; c++) begin
         check("busy_run", busy, 1'b1);
         check("done_run", done, 1'b0);
         check("stall_run", stall, 1'b1);
         check("hi_hold", hi, m_hi);
         check("lo_hold", lo, m_lo);
         hi_we = 1'($urandom_range(0, 1));
         lo_we = 1'($urandom_range(0, 1));
         wdata = $urandom;
         tick();
      end
      hi_we = 1'b0;
      lo_we = 1'b0;
      m_hi  = r[63:32];
      m_lo  = r[31:0];
      check("done_pulse", done, 1'b1);
      check("busy_done", busy, 1'b0);
      check("stall_done", stall, 1'b0);
      check("hi_result", hi, m_hi);
      check("lo_result", lo, m_lo);
      tick();
      check("done_one_cycle", done, 1'b0);
      check("busy_after", busy, 1'b0);
      check("stall_after", stall, keep_start);
      start = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      start    = 1'b0;
      flush    = 1'b0;
      hi_we    = 1'b0;
      lo_we    = 1'b0;
      op       = 2'b00;
      a        = 32'h0;
      b        = 32'h0;
      wdata    = 32'h0;
      m_hi     = 32'h0;
      m_lo     = 32'h0;

      tick();
      tick();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      check("rst_stall0", stall, 1'b0);
      start = 1'b1;
      #1;
      check("rst_stall1", stall, 1'b1);
      start = 1'b0;
      reset = 1'b0;
      tick();

      // Directed vectors with known results.
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      check("multu_hi", hi, 32'hFFFFFFFE);
      check("multu_lo", lo, 32'h00000001);
      run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 1'b1);
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFEB);
      run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0);
      check("div_lo", lo, 32'hFFFFFFFD);
      check("div_hi", hi, 32'hFFFFFFFF);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      check("divovf_lo", lo, 32'h80000000);
      check("divovf_hi", hi, 32'h00000000);
      run_op(2'b11, 32'h00000005, 32'h00000000, 1'b0);
      check("divu0_lo", lo, 32'hFFFFFFFF);
      check("divu0_hi", hi, 32'h00000005);
      run_op(2'b10, 32'hFFFFFFF0, 32'h00000000, 1'b0);
      check("div0_hi", hi, 32'hFFFFFFF0);

      // MTHI then MTLO.
      hi_we = 1'b1;
      wdata = 32'h12345678;
      tick();
      hi_we = 1'b0;
      m_hi  = 32'h12345678;
      check("mthi", hi, m_hi);
      lo_we = 1'b1;
      wdata = 32'h9ABCDEF0;
      tick();
      lo_we = 1'b0;
      m_lo  = 32'h9ABCDEF0;
      check("mtlo", lo, m_lo);

      // DIV aborted by flush at cycle 10, MTHI attempted at cycle 5.
      op    = 2'b10;
      a     = $urandom;
      b     = $urandom | 32'h1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         if (c == 5) begin
            hi_we = 1'b1;
            wdata = 32'hFFFF0000;
         end else begin
            hi_we = 1'b0;
         end
         tick();
      end
      hi_we = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", busy, 1'b0);
      check("flush_hi", hi, m_hi);
      check("flush_lo", lo, m_lo);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) seen++;
         tick();
      end
      check("flush_no_done", seen, 0);
      check("flush_hi_late", hi, m_hi);

      // Flush blocks a start in IDLE but not an MTHI.
      start = 1'b1;
      flush = 1'b1;
      op    = 2'b01;
      hi_we = 1'b1;
      wdata = 32'hCAFEF00D;
      tick();
      start = 1'b0;
      flush = 1'b0;
      hi_we = 1'b0;
      m_hi  = 32'hCAFEF00D;
      check("flush_blocks_start", busy, 1'b0);
      check("mthi_with_flush", hi, m_hi);

      // Simultaneous MTHI and MTLO.
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = $urandom;
      m_hi  = wdata;
      m_lo  = wdata;
      tick();
      hi_we = 1'b0;
      lo_we = 1'b0;
      check("mt_both_hi", hi, m_hi);
      check("mt_both_lo", lo, m_lo);

      // Randomized operations with corner-case injection.
      for (int i = 0; i < 24; i++) begin
         r_op = 2'($urandom);
         r_a  = $urandom;
         r_b  = $urandom;
         sel  = $urandom_range(0, 7);
         if (sel == 0) r_b = 32'h0;
         if (sel == 1) begin
            r_a = 32'h80000000;
            r_b = 32'hFFFFFFFF;
         end
         if (sel == 2) r_b = $urandom_range(1, 15);
         if (sel == 3) r_a = $urandom_range(0, 15);
         run_op(r_op, r_a, r_b, (i % 3) == 0);
      end

      // Reset during a MULT at cycle 20.
      op    = 2'b00;
      a     = $urandom;
      b     = $urandom;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 19; c++) tick();
      reset = 1'b1;
      flush = 1'b1;
      hi_we = 1'b1;
      wdata = 32'h55AA55AA;
      tick();
      flush = 1'b0;
      hi_we = 1'b0;
      m_hi  = 32'h0;
      m_lo  = 32'h0;
      check("rstop_busy", busy, 1'b0);
      check("rstop_done", done, 1'b0);
      check("rstop_hi", hi, m_hi);
      check("rstop_lo", lo, m_lo);
      start = 1'b1;
      #1;
      check("rstop_stall1", stall, 1'b1);
      start = 1'b0;
      #1;
      check("rstop_stall0", stall, 1'b0);
      tick();
      reset = 1'b0;
      seen  = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) seen++;
         tick();
      end
      check("rst_no_done", seen, 0);

      // MTLO in IDLE.
      lo_we = 1'b1;
      wdata = 32'h0000ABCD;
      tick();
      lo_we = 1'b0;
      m_lo  = 32'h0000ABCD;
      check("mtlo_idle", lo, m_lo);
      check("mtlo_hi_kept", hi, m_hi);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
